halfband_decim_sched: RTL

// Clock-enable scheduler for the time-shared polyphase halfband decimator.

---
 rtl/halfband_decim_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/halfband_decim_sched.sv
// Clock-enable scheduler for the time-shared polyphase halfband decimator.
// Optional feature: define SCHED_SYM_COUNT_EN to add the 16-bit sym_count output.
module halfband_decim_sched #(
    parameter int CLK_DIV = 4,
    parameter int DECIM   = 2,
    parameter int SYM_DIV = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sync,
    output logic                       clock_12_5_en,
    output logic                       sam_clk_en,
    output logic                       sym_clk_en,
    output logic [$clog2(DECIM)-1:0]   mac_phase,
`ifdef SCHED_SYM_COUNT_EN
    output logic [15:0]                sym_count,
`endif
    output logic                       acc_clear,
    output logic                       locked
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int PW = $clog2(DECIM);
    localparam int SW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(SYM_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [SW-1:0] SYM_ONE  = SW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [DW-1:0]   div_cnt_r, div_cnt_s;
    logic [PW-1:0]   ph_cnt_r, ph_cnt_s;
    logic [SW-1:0]   sym_cnt_r, sym_cnt_s;
    logic [PW-1:0]   mac_phase_r, mac_phase_s;
    logic            mac_en_r, mac_en_s;
    logic            sam_en_r, sam_en_s;
    logic            sym_en_r, sym_en_s;
    logic            acc_clear_r, acc_clear_s;
    logic            locked_r, locked_s;
    logic            run_s;

    // Next-state and next-output logic; strobes are computed one cycle ahead so they leave registered.
    always_comb begin
        state_s     = state_r;
        div_cnt_s   = div_cnt_r;
        ph_cnt_s    = ph_cnt_r;
        sym_cnt_s   = sym_cnt_r;
        mac_phase_s = mac_phase_r;
        mac_en_s    = 1'b0;
        sam_en_s    = 1'b0;
        sym_en_s    = 1'b0;
        acc_clear_s = 1'b0;
        run_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (enable) state_s = ALIGN;
                else        state_s = IDLE;
            end
            ALIGN, LOCKED: begin
                if (!enable)                          state_s = IDLE;
                else if (sync)                        state_s = ALIGN;
                else if (state_r == ALIGN && sym_en_r) state_s = LOCKED;
                else                                  state_s = state_r;
            end
            default: state_s = IDLE;
        endcase

        // Entering the schedule, a sync, or leaving it all restart the counters from phase 0.
        run_s = (state_r != IDLE) && enable && !sync;

        if (!run_s) begin
            div_cnt_s   = '0;
            ph_cnt_s    = '0;
            sym_cnt_s   = '0;
            mac_phase_s = '0;
        end else begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_s = '0;
                if (ph_cnt_r == PH_LAST) begin
                    ph_cnt_s = '0;
                    if (sym_cnt_r == SYM_LAST) sym_cnt_s = '0;
                    else                       sym_cnt_s = sym_cnt_r + SYM_ONE;
                end else begin
                    ph_cnt_s = ph_cnt_r + PH_ONE;
                end
            end else begin
                div_cnt_s = div_cnt_r + DIV_ONE;
            end

            // ph_cnt/sym_cnt only move after the strobe cycle, so they describe the slot being issued.
            if (div_cnt_s == DIV_LAST) begin
                mac_en_s    = 1'b1;
                mac_phase_s = ph_cnt_r;
                acc_clear_s = (ph_cnt_r == '0);
                sam_en_s    = (ph_cnt_r == PH_LAST);
                sym_en_s    = (ph_cnt_r == PH_LAST) && (sym_cnt_r == SYM_LAST);
            end else begin
                mac_en_s = 1'b0;
            end
        end

        locked_s = (state_s == LOCKED);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            div_cnt_r   <= '0;
            ph_cnt_r    <= '0;
            sym_cnt_r   <= '0;
            mac_phase_r <= '0;
            mac_en_r    <= 1'b0;
            sam_en_r    <= 1'b0;
            sym_en_r    <= 1'b0;
            acc_clear_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            div_cnt_r   <= div_cnt_s;
            ph_cnt_r    <= ph_cnt_s;
            sym_cnt_r   <= sym_cnt_s;
            mac_phase_r <= mac_phase_s;
            mac_en_r    <= mac_en_s;
            sam_en_r    <= sam_en_s;
            sym_en_r    <= sym_en_s;
            acc_clear_r <= acc_clear_s;
            locked_r    <= locked_s;
        end
    end

`ifdef SCHED_SYM_COUNT_EN
    logic [15:0] sym_count_r;

    // Free-running symbol counter, bumped together with the sym_clk_en register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_count_r <= 16'd0;
        end else if (!run_s) begin
            sym_count_r <= 16'd0;
        end else if (sym_en_s) begin
            sym_count_r <= sym_count_r + 16'd1;
        end else begin
            sym_count_r <= sym_count_r;
        end
    end

    assign sym_count = sym_count_r;
`endif

    assign clock_12_5_en = mac_en_r;
    assign sam_clk_en    = sam_en_r;
    assign sym_clk_en    = sym_en_r;
    assign mac_phase     = mac_phase_r;
    assign acc_clear     = acc_clear_r;
    assign locked        = locked_r;

endmodule
